// File: rtl/rob_pkg.sv
// Shared reorder-buffer sizes, entry record and pointer helper.
// Debug monitors import this package to reuse rob_entry_t.
package rob_pkg;

    localparam int WORD_SIZE           = 32;
    localparam int ROB_ENTRIES         = 8;
    localparam int ROB_ENTRY_WIDTH     = $clog2(ROB_ENTRIES);
    localparam int ARCH_REG_INDEX_SIZE = 5;

    typedef logic [ROB_ENTRY_WIDTH-1:0]     rob_id_t;
    typedef logic [ROB_ENTRY_WIDTH:0]       rob_count_t;
    typedef logic [WORD_SIZE-1:0]           word_t;
    typedef logic [ARCH_REG_INDEX_SIZE-1:0] arch_reg_t;

    localparam rob_count_t COUNT_ONE  = rob_count_t'(1);
    localparam rob_count_t COUNT_FULL = rob_count_t'(ROB_ENTRIES);

    typedef struct packed {
        logic      valid;
        logic      ready;
        logic      is_store;
        arch_reg_t rd;
        word_t     data;
    } rob_entry_t;

    // ROB_ENTRIES is a power of two, so the natural index overflow is the wrap.
    function automatic rob_id_t nextId(input rob_id_t id);
        return id + rob_id_t'(1);
    endfunction

endpackage

// File: rtl/rob_wb_merge.sv
// Priority merge of the ALU/MEM/MUL writeback ports into per-entry writes.
// Only allocated entries accept a write; ALU beats MEM beats MUL on a clash.
module rob_wb_merge
    import rob_pkg::*;
(
    input  logic                      alu_en_i,
    input  rob_id_t                   alu_id_i,
    input  word_t                     alu_data_i,
    input  logic                      mem_en_i,
    input  rob_id_t                   mem_id_i,
    input  word_t                     mem_data_i,
    input  logic                      mul_en_i,
    input  rob_id_t                   mul_id_i,
    input  word_t                     mul_data_i,
    input  logic [ROB_ENTRIES-1:0]    entry_valid_i,
    output logic [ROB_ENTRIES-1:0]    wr_en_o,
    output word_t [ROB_ENTRIES-1:0]   wr_data_o
);

    always_comb begin
        for (int i = 0; i < ROB_ENTRIES; i++) begin
            wr_en_o[i]   = 1'b0;
            wr_data_o[i] = '0;
            if (alu_en_i && (alu_id_i == rob_id_t'(i))) begin
                wr_en_o[i]   = entry_valid_i[i];
                wr_data_o[i] = alu_data_i;
            end else if (mem_en_i && (mem_id_i == rob_id_t'(i))) begin
                wr_en_o[i]   = entry_valid_i[i];
                wr_data_o[i] = mem_data_i;
            end else if (mul_en_i && (mul_id_i == rob_id_t'(i))) begin
                wr_en_o[i]   = entry_valid_i[i];
                wr_data_o[i] = mul_data_i;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocation at tail, writeback capture, operand
// lookup and in-order retirement of the head entry onto the commit bus.
module reorder_buffer
    import rob_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      require_rob_entry,
    input  logic      is_store,
    input  arch_reg_t rd,
    output rob_id_t   assigned_rob_id,
    output logic      full,
    input  rob_id_t   rs1_rob_entry,
    input  rob_id_t   rs2_rob_entry,
    output word_t     rob_s1_data,
    output word_t     rob_s2_data,
    output logic      rob_s1_valid,
    output logic      rob_s2_valid,
    input  logic      alu_wb_bypass_enable,
    input  logic      mem_wb_bypass_enable,
    input  logic      mul_wb_bypass_enable,
    input  rob_id_t   alu_wb_rob_id,
    input  rob_id_t   mem_wb_rob_id,
    input  rob_id_t   mul_wb_rob_id,
    input  word_t     alu_wb_data,
    input  word_t     mem_wb_data,
    input  word_t     mul_wb_data,
    input  logic      flush,
    output logic      commit,
    output logic      commit_store,
    output arch_reg_t commit_rd,
    output rob_id_t   commit_rob_id,
    output word_t     din
);

    rob_entry_t entries_q [ROB_ENTRIES];
    rob_entry_t entries_d [ROB_ENTRIES];
    rob_id_t    head_q, head_d;
    rob_id_t    tail_q, tail_d;
    rob_count_t count_q, count_d;

    rob_entry_t                 headEntry;
    logic                       allocEn;
    logic                       retireEn;
    logic [ROB_ENTRIES-1:0]     entryValid;
    logic [ROB_ENTRIES-1:0]     wrEn;
    word_t [ROB_ENTRIES-1:0]    wrData;

    assign headEntry = entries_q[head_q];
    assign full      = (count_q == COUNT_FULL);
    assign retireEn  = headEntry.valid && headEntry.ready;
    assign allocEn   = require_rob_entry && !full && !flush;

    always_comb begin
        for (int i = 0; i < ROB_ENTRIES; i++) begin
            entryValid[i] = entries_q[i].valid;
        end
    end

    rob_wb_merge u_wb_merge (
        .alu_en_i      (alu_wb_bypass_enable),
        .alu_id_i      (alu_wb_rob_id),
        .alu_data_i    (alu_wb_data),
        .mem_en_i      (mem_wb_bypass_enable),
        .mem_id_i      (mem_wb_rob_id),
        .mem_data_i    (mem_wb_data),
        .mul_en_i      (mul_wb_bypass_enable),
        .mul_id_i      (mul_wb_rob_id),
        .mul_data_i    (mul_wb_data),
        .entry_valid_i (entryValid),
        .wr_en_o       (wrEn),
        .wr_data_o     (wrData)
    );

    assign commit          = retireEn && !headEntry.is_store;
    assign commit_store    = retireEn && headEntry.is_store;
    assign commit_rd       = headEntry.rd;
    assign commit_rob_id   = head_q;
    assign din             = headEntry.data;
    assign assigned_rob_id = tail_q;

    // Lookups read registered state only; same-cycle writebacks are bypassed elsewhere.
    assign rob_s1_valid = entries_q[rs1_rob_entry].valid && entries_q[rs1_rob_entry].ready;
    assign rob_s2_valid = entries_q[rs2_rob_entry].valid && entries_q[rs2_rob_entry].ready;
    assign rob_s1_data  = entries_q[rs1_rob_entry].data;
    assign rob_s2_data  = entries_q[rs2_rob_entry].data;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (!flush) begin
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                if (wrEn[i]) begin
                    entries_d[i].data  = wrData[i];
                    entries_d[i].ready = 1'b1;
                end
            end
        end

        if (allocEn) begin
            entries_d[tail_q] = '{valid: 1'b1, ready: 1'b0, is_store: is_store, rd: rd, data: '0};
            tail_d            = nextId(tail_q);
        end

        if (retireEn) begin
            entries_d[head_q].valid = 1'b0;
            entries_d[head_q].ready = 1'b0;
            head_d                  = nextId(head_q);
        end

        case ({allocEn, retireEn})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase

        // The head is older than the flushing branch, so its retirement stands.
        if (flush) begin
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                entries_d[i].valid = 1'b0;
                entries_d[i].ready = 1'b0;
            end
            tail_d  = head_d;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios with literal
// expectations, then random traffic against a program-order queue model.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        requireRobEntry;
    logic        isStore;
    logic [4:0]  rd;
    logic [2:0]  assignedRobId;
    logic        full;
    logic [2:0]  rs1RobEntry, rs2RobEntry;
    logic [31:0] robS1Data, robS2Data;
    logic        robS1Valid, robS2Valid;
    logic        aluEn, memEn, mulEn;
    logic [2:0]  aluId, memId, mulId;
    logic [31:0] aluData, memData, mulData;
    logic        flush;
    logic        commit, commitStore;
    logic [4:0]  commitRd;
    logic [2:0]  commitRobId;
    logic [31:0] din;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk                  (clk),
        .rst                  (rst),
        .require_rob_entry    (requireRobEntry),
        .is_store             (isStore),
        .rd                   (rd),
        .assigned_rob_id      (assignedRobId),
        .full                 (full),
        .rs1_rob_entry        (rs1RobEntry),
        .rs2_rob_entry        (rs2RobEntry),
        .rob_s1_data          (robS1Data),
        .rob_s2_data          (robS2Data),
        .rob_s1_valid         (robS1Valid),
        .rob_s2_valid         (robS2Valid),
        .alu_wb_bypass_enable (aluEn),
        .mem_wb_bypass_enable (memEn),
        .mul_wb_bypass_enable (mulEn),
        .alu_wb_rob_id        (aluId),
        .mem_wb_rob_id        (memId),
        .mul_wb_rob_id        (mulId),
        .alu_wb_data          (aluData),
        .mem_wb_data          (memData),
        .mul_wb_data          (mulData),
        .flush                (flush),
        .commit               (commit),
        .commit_store         (commitStore),
        .commit_rd            (commitRd),
        .commit_rob_id        (commitRobId),
        .din                  (din)
    );

    // In-flight instructions in program order; front is the oldest.
    typedef struct {
        int          id;
        logic [4:0]  rd;
        bit          st;
        bit          rdy;
        logic [31:0] data;
    } entry_t;

    entry_t modelQ[$];
    int     modelTail = 0;

    function automatic int findIdx(input int id);
        for (int k = 0; k < modelQ.size(); k++) begin
            if (modelQ[k].id == id) return k;
        end
        return -1;
    endfunction

    function automatic int modelHead();
        return (modelQ.size() > 0) ? modelQ[0].id : modelTail;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idle();
        requireRobEntry = 1'b0;
        isStore         = 1'b0;
        rd              = '0;
        rs1RobEntry     = '0;
        rs2RobEntry     = '0;
        aluEn = 1'b0; memEn = 1'b0; mulEn = 1'b0;
        aluId = '0;   memId = '0;   mulId = '0;
        aluData = '0; memData = '0; mulData = '0;
        flush           = 1'b0;
    endtask

    task automatic checkLookup(input string name, input logic [2:0] idx, input logic v, input logic [31:0] d);
        int k;
        k = findIdx(int'(idx));
        checkOutput({name, "Valid"}, {31'd0, v}, {31'd0, (k >= 0) && modelQ[k].rdy});
        if (k >= 0) checkOutput({name, "Data"}, d, modelQ[k].data);
    endtask

    task automatic compareModel();
        bit headReady;
        headReady = (modelQ.size() > 0) && modelQ[0].rdy;
        checkOutput("full", {31'd0, full}, {31'd0, modelQ.size() == 8});
        checkOutput("assignedRobId", {29'd0, assignedRobId}, modelTail);
        checkOutput("commitRobId", {29'd0, commitRobId}, modelHead());
        checkOutput("commit", {31'd0, commit}, {31'd0, headReady && !modelQ[0].st});
        checkOutput("commitStore", {31'd0, commitStore}, {31'd0, headReady && modelQ[0].st});
        if (headReady && !modelQ[0].st) begin
            checkOutput("commitRd", {27'd0, commitRd}, {27'd0, modelQ[0].rd});
            checkOutput("din", din, modelQ[0].data);
        end
        checkLookup("s1", rs1RobEntry, robS1Valid, robS1Data);
        checkLookup("s2", rs2RobEntry, robS2Valid, robS2Data);
    endtask

    task automatic applyWb(input logic en, input logic [2:0] id, input logic [31:0] d);
        int     k;
        entry_t e;
        if (en) begin
            k = findIdx(int'(id));
            if (k >= 0) begin
                e = modelQ[k];
                e.rdy = 1'b1;
                e.data = d;
                modelQ[k] = e;
            end
        end
    endtask

    task automatic stepModel();
        bit     headReady;
        bit     wasFull;
        int     newHead;
        entry_t e;
        headReady = (modelQ.size() > 0) && modelQ[0].rdy;
        wasFull   = (modelQ.size() == 8);
        if (flush) begin
            newHead = headReady ? (modelQ[0].id + 1) % 8 : modelHead();
            modelQ.delete();
            modelTail = newHead;
        end else begin
            applyWb(mulEn, mulId, mulData);
            applyWb(memEn, memId, memData);
            applyWb(aluEn, aluId, aluData);
            if (headReady) void'(modelQ.pop_front());
            if (requireRobEntry && !wasFull) begin
                e.id = modelTail; e.rd = rd; e.st = isStore; e.rdy = 1'b0; e.data = '0;
                modelQ.push_back(e);
                modelTail = (modelTail + 1) % 8;
            end
        end
    endtask

    // One clock: compare mid-cycle, advance the model, then let the DUT edge land.
    task automatic applyStimulus();
        @(negedge clk);
        compareModel();
        stepModel();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle();
        rs1RobEntry = 3'd3;
        #2;
        checkOutput("rstFull", {31'd0, full}, 32'd0);
        checkOutput("rstAssigned", {29'd0, assignedRobId}, 32'd0);
        checkOutput("rstCommit", {31'd0, commit}, 32'd0);
        checkOutput("rstCommitStore", {31'd0, commitStore}, 32'd0);
        checkOutput("rstCommitRd", {27'd0, commitRd}, 32'd0);
        checkOutput("rstCommitRobId", {29'd0, commitRobId}, 32'd0);
        checkOutput("rstDin", din, 32'd0);
        checkOutput("rstS1Valid", {31'd0, robS1Valid}, 32'd0);
        checkOutput("rstS1Data", robS1Data, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelQ.delete();
        modelTail = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        idle();
        doReset();

        // Fill all eight entries, then a ninth request while full.
        for (int i = 1; i <= 9; i++) begin
            idle();
            checkOutput("allocId", {29'd0, assignedRobId}, (i - 1) % 8);
            requireRobEntry = 1'b1;
            rd = 5'(i);
            isStore = (i == 4);
            applyStimulus();
        end
        checkOutput("fullAfter8", {31'd0, full}, 32'd1);

        idle(); aluEn = 1'b1; aluId = 3'd0; aluData = 32'hAA;
        applyStimulus();
        checkOutput("c0Commit", {31'd0, commit}, 32'd1);
        checkOutput("c0Rd", {27'd0, commitRd}, 32'd1);
        checkOutput("c0Din", din, 32'hAA);
        checkOutput("c0Id", {29'd0, commitRobId}, 32'd0);

        idle(); requireRobEntry = 1'b1; rd = 5'd9;
        applyStimulus();
        checkOutput("noSameCycleReuse", {31'd0, full}, 32'd0);
        checkOutput("noSameCycleId", {29'd0, assignedRobId}, 32'd0);
        checkOutput("headAfterC0", {29'd0, commitRobId}, 32'd1);

        idle(); requireRobEntry = 1'b1; rd = 5'd9;
        applyStimulus();
        checkOutput("wrapAlloc", {29'd0, assignedRobId}, 32'd1);
        checkOutput("wrapFull", {31'd0, full}, 32'd1);

        idle(); aluEn = 1'b1; aluId = 3'd2; aluData = 32'h22;
        applyStimulus();
        checkOutput("oooNoCommit", {31'd0, commit}, 32'd0);

        idle(); mulEn = 1'b1; mulId = 3'd1; mulData = 32'h11;
        applyStimulus();
        checkOutput("c1Rd", {27'd0, commitRd}, 32'd2);
        checkOutput("c1Din", din, 32'h11);
        idle();
        applyStimulus();
        checkOutput("c2Commit", {31'd0, commit}, 32'd1);
        checkOutput("c2Din", din, 32'h22);
        idle();
        applyStimulus();
        checkOutput("c3Wait", {31'd0, commit | commitStore}, 32'd0);

        idle(); memEn = 1'b1; memId = 3'd3; memData = 32'h33;
        applyStimulus();
        checkOutput("storeCommitStore", {31'd0, commitStore}, 32'd1);
        checkOutput("storeCommit", {31'd0, commit}, 32'd0);
        idle();
        applyStimulus();
        checkOutput("storeOnce", {31'd0, commitStore}, 32'd0);
        checkOutput("headAfterStore", {29'd0, commitRobId}, 32'd4);

        idle(); aluEn = 1'b1; aluId = 3'd4; aluData = 32'h44;
        applyStimulus();
        checkOutput("preFlushCommit", {31'd0, commit}, 32'd1);

        idle(); flush = 1'b1; requireRobEntry = 1'b1; rd = 5'd7;
        aluEn = 1'b1; aluId = 3'd5; aluData = 32'h55; rs1RobEntry = 3'd5;
        applyStimulus();
        checkOutput("flushFull", {31'd0, full}, 32'd0);
        checkOutput("flushTail", {29'd0, assignedRobId}, 32'd5);
        checkOutput("flushHead", {29'd0, commitRobId}, 32'd5);
        checkOutput("flushS1Valid", {31'd0, robS1Valid}, 32'd0);

        idle(); requireRobEntry = 1'b1; rd = 5'd7;
        applyStimulus();
        checkOutput("postFlushAlloc", {29'd0, assignedRobId}, 32'd6);

        // Random traffic, including a mid-run asynchronous reset.
        for (int n = 0; n < 3000; n++) begin
            idle();
            if (n == 1500) doReset();
            requireRobEntry = ($urandom_range(99) < 60);
            isStore         = ($urandom_range(4) == 0);
            rd              = 5'($urandom);
            aluEn = ($urandom_range(99) < 40);
            memEn = ($urandom_range(99) < 40);
            mulEn = ($urandom_range(99) < 40);
            if (modelQ.size() > 0 && $urandom_range(3) != 0) begin
                aluId = 3'(modelQ[$urandom_range(modelQ.size() - 1)].id);
                memId = 3'(modelQ[$urandom_range(modelQ.size() - 1)].id);
                mulId = 3'(modelQ[$urandom_range(modelQ.size() - 1)].id);
            end else begin
                aluId = 3'($urandom); memId = 3'($urandom); mulId = 3'($urandom);
            end
            aluData = $urandom; memData = $urandom; mulData = $urandom;
            flush       = ($urandom_range(99) < 3);
            rs1RobEntry = 3'($urandom);
            rs2RobEntry = 3'($urandom);
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
